// File: rtl/kbd_pkg.sv
// Shared types and constants for the PS/2 keyboard matrix front end.
// Optional build macro used by this slice: KBD_HOTKEY_EN.
package kbd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK,
        SKIP
    } dec_state_t;

    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;
    localparam logic [7:0] SC_PAUSE = 8'hE1;
    localparam logic [7:0] SC_F12   = 8'h07;

    localparam int NROWS_DEF = 10;

    // Bytes following E1 in the Pause make sequence (E1 14 77 E1 F0 14 F0 77).
    localparam logic [2:0] PAUSE_SKIP = 3'd7;

    typedef struct packed {
        logic       hit;
        logic [3:0] row;
        logic [2:0] col;
    } km_res_t;

    // Keyboard status/response codes that never carry key information.
    function automatic logic is_ignored(input logic [7:0] code);
        return (code == 8'hAA) || (code == 8'hFA) || (code == 8'hFE) ||
               (code == 8'hEE) || (code == 8'h00) || (code == 8'hFF);
    endfunction

    function automatic km_res_t km_hit(input logic [3:0] row, input logic [2:0] col);
        km_res_t r;
        r.hit = 1'b1;
        r.row = row;
        r.col = col;
        return r;
    endfunction

endpackage

// File: rtl/kbd_keymap.sv
// Combinational scancode ROM: {ext, code} -> {hit, row, col} of the host key matrix.
// F12 (07) is deliberately unmapped; with KBD_HOTKEY_EN it is handled as a hotkey upstream.
module kbd_keymap
    import kbd_pkg::*;
(
    input  logic       ext,
    input  logic [7:0] code,
    output km_res_t    res
);

    always_comb begin
        res = '0;
        case ({ext, code})
            9'h05A: res = km_hit(4'd0, 3'd0);  // Return
            9'h066: res = km_hit(4'd0, 3'd1);
            9'h076: res = km_hit(4'd0, 3'd2);
            9'h00D: res = km_hit(4'd0, 3'd3);
            9'h029: res = km_hit(4'd0, 3'd4);
            9'h014: res = km_hit(4'd0, 3'd5);
            9'h058: res = km_hit(4'd0, 3'd6);
            9'h011: res = km_hit(4'd0, 3'd7);
            9'h016: res = km_hit(4'd1, 3'd0);
            9'h01E: res = km_hit(4'd1, 3'd1);
            9'h026: res = km_hit(4'd1, 3'd2);
            9'h025: res = km_hit(4'd1, 3'd3);
            9'h02E: res = km_hit(4'd1, 3'd4);
            9'h036: res = km_hit(4'd1, 3'd5);
            9'h03D: res = km_hit(4'd1, 3'd6);
            9'h03E: res = km_hit(4'd1, 3'd7);
            9'h046: res = km_hit(4'd2, 3'd0);
            9'h045: res = km_hit(4'd2, 3'd1);
            9'h04E: res = km_hit(4'd2, 3'd2);
            9'h055: res = km_hit(4'd2, 3'd3);
            9'h054: res = km_hit(4'd2, 3'd4);
            9'h05B: res = km_hit(4'd2, 3'd5);
            9'h05D: res = km_hit(4'd2, 3'd6);
            9'h04C: res = km_hit(4'd2, 3'd7);
            9'h052: res = km_hit(4'd3, 3'd0);
            9'h041: res = km_hit(4'd3, 3'd1);
            9'h049: res = km_hit(4'd3, 3'd2);
            9'h04A: res = km_hit(4'd3, 3'd3);
            9'h00E: res = km_hit(4'd3, 3'd4);
            9'h005: res = km_hit(4'd3, 3'd5);
            9'h006: res = km_hit(4'd3, 3'd6);
            9'h004: res = km_hit(4'd3, 3'd7);
            9'h01C: res = km_hit(4'd4, 3'd0);  // A
            9'h032: res = km_hit(4'd4, 3'd1);
            9'h021: res = km_hit(4'd4, 3'd2);
            9'h023: res = km_hit(4'd4, 3'd3);
            9'h024: res = km_hit(4'd4, 3'd4);
            9'h02B: res = km_hit(4'd4, 3'd5);
            9'h034: res = km_hit(4'd4, 3'd6);
            9'h033: res = km_hit(4'd4, 3'd7);
            9'h043: res = km_hit(4'd5, 3'd0);
            9'h03B: res = km_hit(4'd5, 3'd1);
            9'h042: res = km_hit(4'd5, 3'd2);
            9'h04B: res = km_hit(4'd5, 3'd3);
            9'h03A: res = km_hit(4'd5, 3'd4);
            9'h031: res = km_hit(4'd5, 3'd5);
            9'h044: res = km_hit(4'd5, 3'd6);
            9'h04D: res = km_hit(4'd5, 3'd7);
            9'h015: res = km_hit(4'd6, 3'd0);
            9'h02D: res = km_hit(4'd6, 3'd1);
            9'h01B: res = km_hit(4'd6, 3'd2);
            9'h02C: res = km_hit(4'd6, 3'd3);
            9'h03C: res = km_hit(4'd6, 3'd4);
            9'h02A: res = km_hit(4'd6, 3'd5);
            9'h01D: res = km_hit(4'd6, 3'd6);
            9'h022: res = km_hit(4'd6, 3'd7);
            9'h035: res = km_hit(4'd7, 3'd0);
            9'h01A: res = km_hit(4'd7, 3'd1);
            9'h00C: res = km_hit(4'd7, 3'd2);
            9'h003: res = km_hit(4'd7, 3'd3);
            9'h00B: res = km_hit(4'd7, 3'd4);
            9'h083: res = km_hit(4'd7, 3'd5);
            9'h00A: res = km_hit(4'd7, 3'd6);
            9'h001: res = km_hit(4'd7, 3'd7);
            // Both shifts share one matrix cell; last event wins.
            9'h012: res = km_hit(4'd8, 3'd0);
            9'h059: res = km_hit(4'd8, 3'd0);
            9'h009: res = km_hit(4'd8, 3'd1);
            9'h078: res = km_hit(4'd8, 3'd2);
            9'h07E: res = km_hit(4'd8, 3'd3);
            9'h16B: res = km_hit(4'd9, 3'd0);
            9'h174: res = km_hit(4'd9, 3'd1);
            9'h175: res = km_hit(4'd9, 3'd2);  // Up arrow
            9'h172: res = km_hit(4'd9, 3'd3);
            9'h171: res = km_hit(4'd9, 3'd4);
            9'h170: res = km_hit(4'd9, 3'd5);
            9'h16C: res = km_hit(4'd9, 3'd6);
            9'h169: res = km_hit(4'd9, 3'd7);
            9'h15A: res = km_hit(4'd0, 3'd0);
            9'h114: res = km_hit(4'd0, 3'd5);
            9'h111: res = km_hit(4'd0, 3'd7);
            default: res = '0;
        endcase
    end

endmodule

// File: rtl/kbd_matrix.sv
// PS/2 receiver + scancode decoder maintaining a pressed-key matrix read by the PIO.
// Build macro KBD_HOTKEY_EN: F12 make pulses HOTKEY instead of touching the matrix.
module kbd_matrix
    import kbd_pkg::*;
#(
    parameter int TIMEOUT_TICKS = 4000,
    parameter int NROWS         = NROWS_DEF
) (
    input  logic       CLK,
    input  logic       RST_n,
    input  logic       ENA,
    input  logic       PS2_CLK,
    input  logic       PS2_DAT,
    input  logic [3:0] ROW,
    input  logic       ROW_EN,
    output logic [7:0] COL,
    output logic       KEY_EVT,
    output logic       HOTKEY
);

    localparam int TO_W = $clog2(TIMEOUT_TICKS + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_TICKS - 1);

    logic clk_s1, clk_s2, clk_prev;
    logic dat_s1, dat_s2;
    logic ps2_fall;

    // Idle PS/2 lines are high, so the synchroniser resets high to avoid a false edge.
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            clk_s1   <= 1'b1;
            clk_s2   <= 1'b1;
            clk_prev <= 1'b1;
            dat_s1   <= 1'b1;
            dat_s2   <= 1'b1;
        end else if (ENA) begin
            clk_s1   <= PS2_CLK;
            clk_s2   <= clk_s1;
            clk_prev <= clk_s2;
            dat_s1   <= PS2_DAT;
            dat_s2   <= dat_s1;
        end
    end

    assign ps2_fall = clk_prev & ~clk_s2;

    logic [3:0]      bit_cnt;
    logic [7:0]      shreg;
    logic            par_bit;
    logic [TO_W-1:0] to_cnt;
    logic            byte_vld;
    logic [7:0]      byte_data;

    // byte_vld/byte_data: valid for exactly one ENA tick, no ready; the decoder always accepts.
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            bit_cnt   <= '0;
            shreg     <= '0;
            par_bit   <= 1'b0;
            to_cnt    <= '0;
            byte_vld  <= 1'b0;
            byte_data <= '0;
        end else if (ENA) begin
            byte_vld <= 1'b0;
            if (ps2_fall) begin
                to_cnt <= '0;
                if (bit_cnt == 4'd0) begin
                    if (!dat_s2) bit_cnt <= 4'd1;
                end else if (bit_cnt <= 4'd8) begin
                    shreg   <= {dat_s2, shreg[7:1]};
                    bit_cnt <= bit_cnt + 4'd1;
                end else if (bit_cnt == 4'd9) begin
                    par_bit <= dat_s2;
                    bit_cnt <= 4'd10;
                end else begin
                    bit_cnt <= 4'd0;
                    if (dat_s2 && (^{shreg, par_bit})) begin
                        byte_vld  <= 1'b1;
                        byte_data <= shreg;
                    end
                end
            end else if (bit_cnt != 4'd0) begin
                if (to_cnt == TO_LAST) begin
                    bit_cnt <= 4'd0;
                    to_cnt  <= '0;
                end else begin
                    to_cnt <= to_cnt + 1'b1;
                end
            end else begin
                to_cnt <= '0;
            end
        end
    end

    dec_state_t state, state_nxt;
    logic [2:0] skip_cnt, skip_nxt;
    logic       lk_req, lk_ext, lk_make;
    km_res_t    km;

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state    <= IDLE;
            skip_cnt <= '0;
        end else if (ENA) begin
            state    <= state_nxt;
            skip_cnt <= skip_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        skip_nxt  = skip_cnt;
        if (byte_vld) begin
            case (state)
                IDLE: begin
                    if (byte_data == SC_EXT) begin
                        state_nxt = EXT;
                    end else if (byte_data == SC_BRK) begin
                        state_nxt = BRK;
                    end else if (byte_data == SC_PAUSE) begin
                        state_nxt = SKIP;
                        skip_nxt  = PAUSE_SKIP;
                    end
                end
                EXT:     state_nxt = (byte_data == SC_BRK) ? EXT_BRK : IDLE;
                BRK:     state_nxt = IDLE;
                EXT_BRK: state_nxt = IDLE;
                SKIP: begin
                    skip_nxt = skip_cnt - 3'd1;
                    if (skip_cnt == 3'd1) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

`ifdef KBD_HOTKEY_EN
    logic hot_req;
`endif

    always_comb begin
        lk_req  = 1'b0;
        lk_ext  = 1'b0;
        lk_make = 1'b0;
`ifdef KBD_HOTKEY_EN
        hot_req = 1'b0;
`endif
        if (byte_vld) begin
            case (state)
                IDLE: begin
                    if ((byte_data != SC_EXT) && (byte_data != SC_BRK) &&
                        (byte_data != SC_PAUSE) && !is_ignored(byte_data)) begin
                        lk_req  = 1'b1;
                        lk_make = 1'b1;
`ifdef KBD_HOTKEY_EN
                        if (byte_data == SC_F12) begin
                            lk_req  = 1'b0;
                            hot_req = 1'b1;
                        end
`endif
                    end
                end
                EXT: begin
                    if (byte_data != SC_BRK) begin
                        lk_req  = 1'b1;
                        lk_ext  = 1'b1;
                        lk_make = 1'b1;
                    end
                end
                BRK: lk_req = 1'b1;
                EXT_BRK: begin
                    lk_req = 1'b1;
                    lk_ext = 1'b1;
                end
                default: lk_req = 1'b0;
            endcase
        end
    end

    kbd_keymap u_keymap (
        .ext  (lk_ext),
        .code (byte_data),
        .res  (km)
    );

    logic [7:0] matrix [NROWS];

    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            for (int r = 0; r < NROWS; r++) matrix[r] <= '0;
            KEY_EVT <= 1'b0;
        end else if (ENA) begin
            KEY_EVT <= 1'b0;
            if (lk_req && km.hit && (int'(km.row) < NROWS)) begin
                matrix[km.row][km.col] <= lk_make;
                KEY_EVT                <= 1'b1;
            end
        end
    end

`ifdef KBD_HOTKEY_EN
    always_ff @(posedge CLK) begin
        if (!RST_n)   HOTKEY <= 1'b0;
        else if (ENA) HOTKEY <= hot_req;
    end
`else
    assign HOTKEY = 1'b0;
`endif

    always_comb begin
        COL = 8'hFF;
        if (ROW_EN && (int'(ROW) < NROWS)) COL = ~matrix[ROW];
    end

endmodule

// File: tb/tb_kbd_matrix.sv
// Directed bench for kbd_matrix: PS/2 frames driven bit by bit, matrix read back through ROW/COL.
module tb_kbd_matrix;

    localparam int HALF = 8;
    localparam int GAP  = 20;

    logic       CLK = 1'b0;
    logic       RST_n = 1'b0;
    logic       ENA = 1'b1;
    logic       PS2_CLK = 1'b1;
    logic       PS2_DAT = 1'b1;
    logic [3:0] ROW = 4'd0;
    logic       ROW_EN = 1'b1;
    logic [7:0] COL;
    logic       KEY_EVT;
    logic       HOTKEY;

    int checks = 0;
    int errors = 0;
    int evt_cnt = 0;
    int hot_cnt = 0;

    kbd_matrix dut (
        .CLK     (CLK),
        .RST_n   (RST_n),
        .ENA     (ENA),
        .PS2_CLK (PS2_CLK),
        .PS2_DAT (PS2_DAT),
        .ROW     (ROW),
        .ROW_EN  (ROW_EN),
        .COL     (COL),
        .KEY_EVT (KEY_EVT),
        .HOTKEY  (HOTKEY)
    );

    always #5 CLK = ~CLK;

    always @(negedge CLK) begin
        if (KEY_EVT) evt_cnt++;
        if (HOTKEY)  hot_cnt++;
    end

    task automatic ps2_bit(input logic b);
        @(negedge CLK);
        PS2_DAT = b;
        repeat (HALF) @(negedge CLK);
        PS2_CLK = 1'b0;
        repeat (HALF) @(negedge CLK);
        PS2_CLK = 1'b1;
    endtask

    // Sends start, data, parity, then drops the clock for the stop bit and returns at that edge.
    task automatic ps2_to_stop(input logic [7:0] d, input logic flip);
        logic [10:0] bits;
        bits = {1'b1, ~(^d) ^ flip, d, 1'b0};
        for (int i = 0; i < 10; i++) ps2_bit(bits[i]);
        @(negedge CLK);
        PS2_DAT = 1'b1;
        repeat (HALF) @(negedge CLK);
        PS2_CLK = 1'b0;
    endtask

    task automatic ps2_finish();
        repeat (HALF) @(negedge CLK);
        PS2_CLK = 1'b1;
        repeat (GAP) @(negedge CLK);
    endtask

    task automatic send_byte(input logic [7:0] d);
        ps2_to_stop(d, 1'b0);
        ps2_finish();
    endtask

    task automatic send_partial(input logic [7:0] d, input int nbits);
        logic [10:0] bits;
        bits = {1'b1, ~(^d), d, 1'b0};
        for (int i = 0; i < nbits; i++) ps2_bit(bits[i]);
    endtask

    task automatic test_reset();
        RST_n = 1'b0;
        ROW = 4'd4;
        ROW_EN = 1'b1;
        repeat (3) @(negedge CLK);
        checks++; if (COL !== 8'hFF) begin errors++; $display("FAIL reset_col: got %h expected %h", COL, 8'hFF); end
        checks++; if (KEY_EVT !== 1'b0) begin errors++; $display("FAIL reset_key_evt: got %b expected 0", KEY_EVT); end
        checks++; if (HOTKEY !== 1'b0) begin errors++; $display("FAIL reset_hotkey: got %b expected 0", HOTKEY); end
        RST_n = 1'b1;
        repeat (GAP) @(negedge CLK);
    endtask

    task automatic test_make_break();
        int e0;
        ROW = 4'd4;
        e0 = evt_cnt;
        ps2_to_stop(8'h1C, 1'b0);
        repeat (3) @(posedge CLK);
        #1;
        checks++; if (COL !== 8'hFF) begin errors++; $display("FAIL make_early_col: got %h expected %h", COL, 8'hFF); end
        checks++; if (KEY_EVT !== 1'b0) begin errors++; $display("FAIL make_early_evt: got %b expected 0", KEY_EVT); end
        @(posedge CLK);
        #1;
        checks++; if (COL !== 8'hFE) begin errors++; $display("FAIL make_col: got %h expected %h", COL, 8'hFE); end
        checks++; if (KEY_EVT !== 1'b1) begin errors++; $display("FAIL make_evt: got %b expected 1", KEY_EVT); end
        @(posedge CLK);
        #1;
        checks++; if (KEY_EVT !== 1'b0) begin errors++; $display("FAIL make_evt_width: got %b expected 0", KEY_EVT); end
        ps2_finish();
        send_byte(8'hF0);
        send_byte(8'h1C);
        checks++; if (COL !== 8'hFF) begin errors++; $display("FAIL break_col: got %h expected %h", COL, 8'hFF); end
        checks++; if (evt_cnt - e0 !== 2) begin errors++; $display("FAIL make_break_evts: got %0d expected 2", evt_cnt - e0); end
    endtask

    task automatic test_bad_parity();
        int e0;
        ROW = 4'd0;
        e0 = evt_cnt;
        ps2_to_stop(8'h5A, 1'b1);
        ps2_finish();
        checks++; if (COL !== 8'hFF) begin errors++; $display("FAIL parity_col: got %h expected %h", COL, 8'hFF); end
        checks++; if (evt_cnt - e0 !== 0) begin errors++; $display("FAIL parity_evts: got %0d expected 0", evt_cnt - e0); end
        send_byte(8'h5A);
        checks++; if (COL !== 8'hFE) begin errors++; $display("FAIL parity_good_col: got %h expected %h", COL, 8'hFE); end
        send_byte(8'hF0);
        send_byte(8'h5A);
        checks++; if (COL !== 8'hFF) begin errors++; $display("FAIL parity_release_col: got %h expected %h", COL, 8'hFF); end
    endtask

    task automatic test_timeout();
        ROW = 4'd8;
        send_partial(8'h33, 6);
        repeat (4010) @(negedge CLK);
        send_byte(8'h12);
        checks++; if (COL !== 8'hFE) begin errors++; $display("FAIL timeout_resync_col: got %h expected %h", COL, 8'hFE); end
        ROW_EN = 1'b0;
        #1;
        checks++; if (COL !== 8'hFF) begin errors++; $display("FAIL row_en_off_col: got %h expected %h", COL, 8'hFF); end
        ROW_EN = 1'b1;
        ROW = 4'd10;
        #1;
        checks++; if (COL !== 8'hFF) begin errors++; $display("FAIL row10_col: got %h expected %h", COL, 8'hFF); end
        ROW = 4'd15;
        #1;
        checks++; if (COL !== 8'hFF) begin errors++; $display("FAIL row15_col: got %h expected %h", COL, 8'hFF); end
        ROW = 4'd8;
        send_byte(8'hF0);
        send_byte(8'h12);
        checks++; if (COL !== 8'hFF) begin errors++; $display("FAIL shift_release_col: got %h expected %h", COL, 8'hFF); end
    endtask

    task automatic test_extended();
        int e0;
        ROW = 4'd9;
        send_byte(8'hE0);
        send_byte(8'h75);
        checks++; if (COL !== 8'hFB) begin errors++; $display("FAIL ext_up_col: got %h expected %h", COL, 8'hFB); end
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        checks++; if (COL !== 8'hFF) begin errors++; $display("FAIL ext_up_release_col: got %h expected %h", COL, 8'hFF); end
        e0 = evt_cnt;
        send_byte(8'h75);
        send_byte(8'hAA);
        send_byte(8'hFA);
        checks++; if (COL !== 8'hFF) begin errors++; $display("FAIL plain75_col: got %h expected %h", COL, 8'hFF); end
        checks++; if (evt_cnt - e0 !== 0) begin errors++; $display("FAIL plain75_evts: got %0d expected 0", evt_cnt - e0); end
    endtask

    task automatic test_pause();
        logic [7:0] seq [8];
        logic [7:0] exp_col;
        int e0;
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        e0 = evt_cnt;
        for (int i = 0; i < 8; i++) send_byte(seq[i]);
        checks++; if (evt_cnt - e0 !== 0) begin errors++; $display("FAIL pause_evts: got %0d expected 0", evt_cnt - e0); end
        send_byte(8'h1C);
        for (int r = 0; r < 10; r++) begin
            ROW = 4'(r);
            exp_col = (r == 4) ? 8'hFE : 8'hFF;
            #1;
            checks++; if (COL !== exp_col) begin errors++; $display("FAIL pause_row%0d_col: got %h expected %h", r, COL, exp_col); end
        end
        checks++; if (evt_cnt - e0 !== 1) begin errors++; $display("FAIL pause_then_a_evts: got %0d expected 1", evt_cnt - e0); end
        send_byte(8'hF0);
        send_byte(8'h1C);
    endtask

    task automatic test_hotkey();
        int e0, h0, exp_hot;
`ifdef KBD_HOTKEY_EN
        exp_hot = 1;
`else
        exp_hot = 0;
`endif
        e0 = evt_cnt;
        h0 = hot_cnt;
        send_byte(8'h07);
        checks++; if (hot_cnt - h0 !== exp_hot) begin errors++; $display("FAIL f12_hotkey: got %0d expected %0d", hot_cnt - h0, exp_hot); end
        checks++; if (evt_cnt - e0 !== 0) begin errors++; $display("FAIL f12_evts: got %0d expected 0", evt_cnt - e0); end
        send_byte(8'hF0);
        send_byte(8'h07);
        checks++; if (hot_cnt - h0 !== exp_hot) begin errors++; $display("FAIL f12_break_hotkey: got %0d expected %0d", hot_cnt - h0, exp_hot); end
    endtask

    task automatic test_same_cell();
        int e0;
        ROW = 4'd8;
        e0 = evt_cnt;
        send_byte(8'h12);
        send_byte(8'h59);
        checks++; if (COL !== 8'hFE) begin errors++; $display("FAIL both_shift_col: got %h expected %h", COL, 8'hFE); end
        send_byte(8'hF0);
        send_byte(8'h59);
        checks++; if (COL !== 8'hFF) begin errors++; $display("FAIL rshift_release_col: got %h expected %h", COL, 8'hFF); end
        checks++; if (evt_cnt - e0 !== 3) begin errors++; $display("FAIL same_cell_evts: got %0d expected 3", evt_cnt - e0); end
    endtask

    task automatic test_back_to_back();
        int e0;
        ROW = 4'd4;
        e0 = evt_cnt;
        send_byte(8'h1C);
        send_byte(8'h1C);
        checks++; if (COL !== 8'hFE) begin errors++; $display("FAIL repeat_make_col: got %h expected %h", COL, 8'hFE); end
        checks++; if (evt_cnt - e0 !== 2) begin errors++; $display("FAIL repeat_make_evts: got %0d expected 2", evt_cnt - e0); end
    endtask

    task automatic test_reset_mid_frame();
        ROW = 4'd4;
        send_partial(8'h5A, 5);
        @(negedge CLK);
        RST_n = 1'b0;
        repeat (2) @(negedge CLK);
        RST_n = 1'b1;
        repeat (GAP) @(negedge CLK);
        checks++; if (COL !== 8'hFF) begin errors++; $display("FAIL mid_reset_col: got %h expected %h", COL, 8'hFF); end
        send_byte(8'h1C);
        checks++; if (COL !== 8'hFE) begin errors++; $display("FAIL after_reset_frame_col: got %h expected %h", COL, 8'hFE); end
    endtask

    initial begin
        test_reset();
        test_make_break();
        test_bad_parity();
        test_timeout();
        test_extended();
        test_pause();
        test_hotkey();
        test_same_cell();
        test_back_to_back();
        test_reset_mid_frame();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
